systolic_mm: RTL
================

# systolic_mm

Parametrised N×N output-stationary systolic matrix multiplier that computes C = A·B, or C += A·B in accumulate mode, for square matrices of DW-bit elements. It generalises the fixed 2×2, 4-bit systolic multiplier:
- size, element width and signedness are parameters;
- the in_val-only interface becomes a full valid/ready handshake on both sides;
- results are held under output backpressure.

The block sits between the operand staging logic and the result consumer in the systol datapath.

## Interface
Parameters:
- N, default 2: matrix dimension; the block contains an N×N PE grid; N ≥ 2.
- DW, default 4: operand element width.
- SIGNED, default 0: 1 gives two's-complement operands and results; 0 gives unsigned.
- AW, default 2*DW+$clog2(N): result element width.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  reset; **one clock; reset is asynchronous and active-high**.
- in_val  in  1  operand pair valid.
- in_rdy  out  1  block can accept an operand pair; high only in IDLE and never while rst is high.
- acc  in  1  sampled with the operand pair; 1 means accumulate onto the previous C.
- a  in  N*N*DW  matrix A, row-major; element (i,k) is at [(i*N+k)*DW +: DW].
- b  in  N*N*DW  matrix B, row-major; element (k,j) is at [(k*N+j)*DW +: DW].
- out_val  out  1  C valid and stable.
- out_rdy  in  1  consumer accepts C.
- c  out  N*N*AW  matrix C, row-major; element (i,j) is at [(i*N+j)*AW +: AW].

## Operation
- FSM states are IDLE, COMPUTE and DONE. Reset state is IDLE.
- Reset values: out_val=0, c=0, step counter 0, all PE pipeline registers 0. in_rdy=0 while rst is high.
- IDLE:
  - in_rdy=1.
  - On in_val&in_rdy, register a and b internally and go to COMPUTE with step=0.
  - If acc=0, clear all accumulators on the same edge; if acc=1, keep them.
- COMPUTE:
  - Runs for 3N-2 cycles, step 0..3N-3.
  - Row skew: row i of A enters the left edge delayed by i cycles.
  - Column skew: column j of B enters the top edge delayed by j cycles.
  - At step t, PE(i,j) computes acc_ij += a(i,k)·b(k,j) with k = t-i-j, only when 0 ≤ k < N; otherwise it receives a zero bubble.
  - A values pass right and B values pass down with one register per PE.
  - Go to DONE on the edge that completes step 3N-3.
- DONE:
  - out_val=1, and c shows the accumulators.
  - On out_val&out_rdy, go to IDLE.
  - c keeps its value after leaving DONE; only the next acc=0 accept clears it.
- Arithmetic:
  - Product width is 2*DW, sign-extended if SIGNED=1, otherwise zero-extended, to AW bits.
  - Accumulation is modulo 2^AW and wraps silently with no saturation. A single A·B never overflows at the default AW.
- in_val and out_rdy are ignored outside IDLE and DONE respectively. Operand inputs may change freely after the accepting edge.

## Timing
- Latency: out_val rises after the edge at accept+3N-2 (4 edges for N=2, 7 for N=3).
- Throughput: one matrix product per 3N cycles minimum (3N-2 compute cycles, at least 1 DONE cycle, 1 IDLE cycle). IDLE and DONE never overlap.
- If out_rdy is already high when out_val rises, the block spends exactly one cycle in DONE.
- Under backpressure, out_val stays high and c is bit-stable for any number of cycles.
- Reset asserted mid-COMPUTE or in DONE:
  - out_val and c clear immediately (asynchronously).
  - in_rdy returns to 1 on the first clk edge after rst deasserts.
  - No partial result is ever presented.

## Test plan
- Basic product (N=2, DW=4): A=[[1,2],[3,4]], B=[[5,6],[7,8]], acc=0 -> out_val after 4 edges; c=[[19,22],[43,50]]; in_rdy low throughout.
- Maximum operands (N=2, DW=4): all operands 15 -> every c element is 450; AW=9, so no wrap.
- Accumulate: the basic case, then the same operands again with acc=1 -> c=[[38,44],[86,100]]. Then acc=1 with A=0 -> c unchanged.
- Backpressure: hold out_rdy=0 for 5 cycles after out_val -> c stable, in_val=1 not accepted, in_rdy=0. Raise out_rdy -> IDLE next cycle, then in_rdy=1.
- Reset mid-operation: assert rst at step 2 of a computation -> out_val=0 and c=0 immediately. A new product after release gives the correct C with no residue from the aborted run.
- Signed, larger grid (N=3, DW=4, SIGNED=1, AW=10):
  - All A and B elements -8 -> every c element is 192, out_val after 7 edges.
  - A=identity, B elements -1 -> every c element is -1 (0x3FF).

Source files
------------

// File: rtl/systolic_mm.sv
// N x N output-stationary systolic matrix multiplier: C = A*B, or C += A*B when acc is set.
// Operands are latched on accept and then streamed through the PE grid with row and column skew.
module systolic_mm #(
    parameter int N      = 2,
    parameter int DW     = 4,
    parameter int SIGNED = 0,
    parameter int AW     = 2*DW + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic              acc,
    input  logic [N*N*DW-1:0] a,
    input  logic [N*N*DW-1:0] b,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [N*N*AW-1:0] c
);
    localparam int LAST = 3*N - 3;
    localparam int SW   = $clog2(3*N);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_live;
    logic [SW-1:0] r_step;
    logic [DW-1:0] r_amat [N][N];
    logic [DW-1:0] r_bmat [N][N];
    logic [DW-1:0] r_a    [N][N];
    logic [DW-1:0] r_b    [N][N];
    logic [AW-1:0] r_acc  [N][N];
    logic [DW-1:0] w_ain  [N][N];
    logic [DW-1:0] w_bin  [N][N];
    logic          w_accept;
    logic          w_last;

    // Product of two elements, widened to the accumulator width with the operand signedness.
    function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic signed [2*DW-1:0] ps;
        logic        [2*DW-1:0] pu;
        ps = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{y[DW-1]}}, y});
        pu = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        if (SIGNED != 0)
            return {{(AW-2*DW){ps[2*DW-1]}}, ps};
        else
            return {{(AW-2*DW){1'b0}}, pu};
    endfunction

    // r_live holds in_rdy low until the first clock edge after reset is released.
    assign in_rdy   = (r_state == S_IDLE) && r_live && !rst;
    assign out_val  = (r_state == S_DONE);
    assign w_accept = in_val && in_rdy;
    assign w_last   = (r_step == SW'(LAST));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_COMPUTE;
            S_COMPUTE: if (w_last)   w_next = S_DONE;
            S_DONE:    if (out_rdy)  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Edge feeders: row i sees a(i,t-i), column j sees b(t-j,j); anything out of range is a bubble.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_ain[i][j] = '0;
                w_bin[i][j] = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(r_step) == i + k) w_ain[i][0] = r_amat[i][k];
                if (int'(r_step) == i + k) w_bin[0][i] = r_bmat[k][i];
            end
            for (int j = 1; j < N; j++) begin
                w_ain[i][j] = r_a[i][j-1];
                w_bin[j][i] = r_b[j-1][i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_step  <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_amat[i][j] <= '0;
                    r_bmat[i][j] <= '0;
                    r_a[i][j]    <= '0;
                    r_b[i][j]    <= '0;
                    r_acc[i][j]  <= '0;
                end
            end
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_step <= '0;
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        r_amat[i][j] <= a[(i*N+j)*DW +: DW];
                        r_bmat[i][j] <= b[(i*N+j)*DW +: DW];
                        r_a[i][j]    <= '0;
                        r_b[i][j]    <= '0;
                        if (!acc) r_acc[i][j] <= '0;
                    end
                end
            end else if (r_state == S_COMPUTE) begin
                r_step <= r_step + SW'(1);
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        r_a[i][j]   <= w_ain[i][j];
                        r_b[i][j]   <= w_bin[i][j];
                        r_acc[i][j] <= r_acc[i][j] + mul_ext(w_ain[i][j], w_bin[i][j]);
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign c[(gi*N+gj)*AW +: AW] = r_acc[gi][gj];
        end
    end
endmodule
